// File: rtl/norm_shift.sv
// Post-add normalization: leading-zero count in stage 1, then shift and exponent
// adjust in stage 2, so the hidden bit lands at bit FW-2 for the rounder.
module norm_shift #(
  parameter int FW = 57,
  parameter int EW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] fs,
  input  logic [10:0]   es,
  input  logic          ss,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-2:0] fn,
  output logic [EW-1:0] en,
  output logic          sn,
  output logic          zero
);

  localparam int LZW = $clog2(FW);

  // Flow control
  logic adv1, adv2;
  logic v1_q, v1_d, v2_q, v2_d;

  // Stage 1 registers
  logic [FW-1:0]  fs1_q, fs1_d;
  logic [10:0]    es1_q, es1_d;
  logic           ss1_q, ss1_d;
  logic [LZW-1:0] lz1_q, lz1_d;
  logic           zr1_q, zr1_d;

  // Stage 2 (output) registers
  logic [FW-2:0]  fn_q, fn_d;
  logic [EW-1:0]  en_q, en_d;
  logic           sn_q, sn_d;
  logic           zero_q, zero_d;

  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // Leading-zero count of the bits below the carry; the highest set bit wins.
  logic [LZW-1:0] lz_calc;
  always_comb begin
    lz_calc = LZW'(FW - 1);
    for (int i = 0; i < FW - 1; i++) begin
      if (fs[i]) lz_calc = LZW'(FW - 2 - i);
    end
  end

  always_comb begin
    v1_d  = v1_q;
    fs1_d = fs1_q;
    es1_d = es1_q;
    ss1_d = ss1_q;
    lz1_d = lz1_q;
    zr1_d = zr1_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        fs1_d = fs;
        es1_d = es;
        ss1_d = ss;
        lz1_d = lz_calc;
        zr1_d = (fs == '0);
      end
    end
  end

  always_comb begin
    v2_d   = v2_q;
    fn_d   = fn_q;
    en_d   = en_q;
    sn_d   = sn_q;
    zero_d = zero_q;
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        if (zr1_q) begin
          fn_d   = '0;
          en_d   = '0;
          sn_d   = 1'b0;
          zero_d = 1'b1;
        end else if (fs1_q[FW-1]) begin
          // Carry-out: right by one, folding the dropped bit into sticky.
          fn_d   = {fs1_q[FW-1:2], fs1_q[1] | fs1_q[0]};
          en_d   = EW'(es1_q) + EW'(1);
          sn_d   = ss1_q;
          zero_d = 1'b0;
        end else begin
          // Exponent may go negative here; underflow is handled downstream.
          fn_d   = fs1_q[FW-2:0] << lz1_q;
          en_d   = EW'(es1_q) - EW'(lz1_q);
          sn_d   = ss1_q;
          zero_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      fs1_q  <= '0;
      es1_q  <= '0;
      ss1_q  <= 1'b0;
      lz1_q  <= '0;
      zr1_q  <= 1'b0;
      fn_q   <= '0;
      en_q   <= '0;
      sn_q   <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      fs1_q  <= fs1_d;
      es1_q  <= es1_d;
      ss1_q  <= ss1_d;
      lz1_q  <= lz1_d;
      zr1_q  <= zr1_d;
      fn_q   <= fn_d;
      en_q   <= en_d;
      sn_q   <= sn_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = v2_q;
  assign fn        = fn_q;
  assign en        = en_q;
  assign sn        = sn_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_norm_shift.sv
// Directed bench for norm_shift: vector table through an idle pipe, then
// back-pressure streaming and mid-flight reset sequences.
module tb_norm_shift;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [56:0] fs;
  logic [10:0] es;
  logic        ss;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] fn;
  logic [12:0] en;
  logic        sn;
  logic        zero;

  always #5 clk = ~clk;

  norm_shift #(.FW(57), .EW(13)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fs(fs), .es(es), .ss(ss), .out_valid(out_valid), .out_ready(out_ready),
    .fn(fn), .en(en), .sn(sn), .zero(zero)
  );

  typedef struct {
    logic [56:0] fs;
    logic [10:0] es;
    logic        ss;
    logic [55:0] fn;
    logic [12:0] en;
    logic        sn;
    logic        zr;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input int i);
    fs = vecs[i].fs;
    es = vecs[i].es;
    ss = vecs[i].ss;
  endtask

  task automatic chk_out(input string tag, input int i);
    chk({tag, ".fn"},   64'(fn),   64'(vecs[i].fn));
    chk({tag, ".en"},   64'(en),   64'(vecs[i].en));
    chk({tag, ".sn"},   64'(sn),   64'(vecs[i].sn));
    chk({tag, ".zero"}, 64'(zero), 64'(vecs[i].zr));
  endtask

  int bp_idx[4] = '{0, 1, 2, 7};

  initial begin
    vecs[0] = '{57'h080_0000_0000_0000, 11'd1023, 1'b1, 56'h80_0000_0000_0000, 13'd1023,  1'b1, 1'b0};
    vecs[1] = '{57'h100_0000_0000_0001, 11'd1023, 1'b0, 56'h80_0000_0000_0001, 13'd1024,  1'b0, 1'b0};
    vecs[2] = '{57'h000_0000_0000_0001, 11'd10,   1'b0, 56'h80_0000_0000_0000, 13'h1FD3,  1'b0, 1'b0};
    vecs[3] = '{57'h000_0000_0000_0000, 11'd500,  1'b1, 56'h00_0000_0000_0000, 13'd0,     1'b0, 1'b1};
    vecs[4] = '{57'h1FF_FFFF_FFFF_FFFF, 11'd2047, 1'b1, 56'hFF_FFFF_FFFF_FFFF, 13'h0800,  1'b1, 1'b0};
    vecs[5] = '{57'h07F_FFFF_FFFF_FFFF, 11'd100,  1'b0, 56'hFF_FFFF_FFFF_FFFE, 13'd99,    1'b0, 1'b0};
    vecs[6] = '{57'h080_0000_0000_0003, 11'd5,    1'b1, 56'h80_0000_0000_0003, 13'd5,     1'b1, 1'b0};
    vecs[7] = '{57'h00A_BCDE_F012_3456, 11'd3,    1'b0, 56'hAB_CDEF_0123_4560, 13'h1FFF,  1'b0, 1'b0};
    vecs[8] = '{57'h040_0000_0000_0000, 11'd0,    1'b1, 56'h80_0000_0000_0000, 13'h1FFF,  1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fs = '0; es = '0; ss = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.fn",        64'(fn),        64'd0);
    chk("rst.en",        64'(en),        64'd0);
    chk("rst.sn",        64'(sn),        64'd0);
    chk("rst.zero",      64'(zero),      64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);

    // Single beats through an idle pipe: two-cycle latency each.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(i); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("v%0d.lat1", i), 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d.valid", i), 64'(out_valid), 64'd1);
      chk_out($sformatf("v%0d", i), i);
      $display("vec %0d: fs=%h es=%0d -> fn=%h en=%h sn=%0d zero=%0d",
               i, vecs[i].fs, vecs[i].es, fn, en, sn, zero);
    end
    @(negedge clk);

    // Back-pressure: 4 beats streamed with out_ready low for the first 5 cycles.
    begin
      int sent = 0, rcv = 0, full_seen = 0, hold_valid = 0;
      logic [55:0] hold_fn;
      logic [12:0] hold_en;
      hold_fn = '0; hold_en = '0;
      for (int c = 0; c < 40 && rcv < 4; c++) begin
        @(negedge clk);
        out_ready = (c >= 5);
        in_valid  = (sent < 4);
        if (sent < 4) drive(bp_idx[sent]);
        #1;
        if (hold_valid != 0 && out_valid) begin
          chk($sformatf("bp.stable_fn c%0d", c), 64'(fn), 64'(hold_fn));
          chk($sformatf("bp.stable_en c%0d", c), 64'(en), 64'(hold_en));
        end
        hold_valid = (out_valid && !out_ready) ? 1 : 0;
        hold_fn = fn; hold_en = en;
        if (!in_ready) full_seen = 1;
        if (out_valid && out_ready) begin
          chk_out($sformatf("bp%0d", rcv), bp_idx[rcv]);
          $display("bp beat %0d out: fn=%h en=%h", rcv, fn, en);
          rcv++;
        end
        if (in_valid && in_ready) sent++;
      end
      chk("bp.received", 64'(rcv), 64'd4);
      chk("bp.full_seen", 64'(full_seen), 64'd1);
      @(negedge clk); in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("bp.no_extra", 64'(out_valid), 64'd0);
    end

    // Reset with two beats in flight: neither may ever appear.
    @(negedge clk);
    out_ready = 1'b0; drive(0); in_valid = 1'b1;
    @(negedge clk);
    drive(1);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst.fn",        64'(fn),        64'd0);
    chk("mid_rst.in_ready",  64'(in_ready),  64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("mid_rst.quiet c%0d", c), 64'(out_valid), 64'd0);
    end
    $display("mid-flight reset: pipeline drained with no output");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
